// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the execute unit: opcodes, ALU operations
// and branch conditions.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        BR_NONE   = 3'd0,
        BR_ALWAYS = 3'd1,
        BR_EQ     = 3'd2,
        BR_NE     = 3'd3,
        BR_LT     = 3'd4,
        BR_GE     = 3'd5,
        BR_LTU    = 3'd6,
        BR_GEU    = 3'd7
    } br_cond_t;

endpackage

// File: rtl/rv_alu.sv
// 32-bit RV32I ALU; shift amount taken from b[4:0], undefined ops yield 0.
module rv_alu
    import rv_pkg::*;
(
    input  logic [3:0]  alu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            ALU_SLL:    result = a << b[4:0];
            ALU_SLT:    result = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU:   result = {31'd0, a < b};
            ALU_XOR:    result = a ^ b;
            ALU_SRL:    result = a >> b[4:0];
            ALU_SRA:    result = $signed(a) >>> b[4:0];
            ALU_OR:     result = a | b;
            ALU_AND:    result = a & b;
            ALU_PASS_B: result = b;
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/rv_branch.sv
// Branch condition evaluator on the two register operands.
module rv_branch
    import rv_pkg::*;
(
    input  logic [2:0]  br_cond,
    input  logic [31:0] rs1_value,
    input  logic [31:0] rs2_value,
    output logic        taken
);

    always_comb begin
        taken = 1'b0;
        case (br_cond)
            BR_ALWAYS: taken = 1'b1;
            BR_EQ:     taken = (rs1_value == rs2_value);
            BR_NE:     taken = (rs1_value != rs2_value);
            BR_LT:     taken = ($signed(rs1_value) <  $signed(rs2_value));
            BR_GE:     taken = ($signed(rs1_value) >= $signed(rs2_value));
            BR_LTU:    taken = (rs1_value <  rs2_value);
            BR_GEU:    taken = (rs1_value >= rs2_value);
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv_ctrl.sv
// Instruction decoder: maps opcode/funct fields to ALU operation,
// operand selects, branch condition and write enable.
module rv_ctrl
    import rv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_op,
    output logic [2:0] br_cond,
    output logic       a_sel_pc,
    output logic       b_sel_imm,
    output logic       link,
    output logic       jalr,
    output logic       reg_write_en
);

    // funct7[5] only means SUB for R-type; for immediates it only means SRAI.
    function automatic alu_op_t f3_to_op(input logic [2:0] f3, input logic f7b, input logic is_r);
        case (f3)
            3'b000:  f3_to_op = (is_r && f7b) ? ALU_SUB : ALU_ADD;
            3'b001:  f3_to_op = ALU_SLL;
            3'b010:  f3_to_op = ALU_SLT;
            3'b011:  f3_to_op = ALU_SLTU;
            3'b100:  f3_to_op = ALU_XOR;
            3'b101:  f3_to_op = f7b ? ALU_SRA : ALU_SRL;
            3'b110:  f3_to_op = ALU_OR;
            default: f3_to_op = ALU_AND;
        endcase
    endfunction

    alu_op_t  op;
    br_cond_t cond;

    always_comb begin
        op           = ALU_ADD;
        cond         = BR_NONE;
        a_sel_pc     = 1'b0;
        b_sel_imm    = 1'b1;
        link         = 1'b0;
        jalr         = 1'b0;
        reg_write_en = 1'b0;
        case (opcode)
            OP_R: begin
                op           = f3_to_op(funct3, funct7_5, 1'b1);
                b_sel_imm    = 1'b0;
                reg_write_en = 1'b1;
            end
            OP_IMM: begin
                op           = f3_to_op(funct3, funct7_5, 1'b0);
                reg_write_en = 1'b1;
            end
            OP_LUI: begin
                op           = ALU_PASS_B;
                reg_write_en = 1'b1;
            end
            OP_AUIPC: begin
                a_sel_pc     = 1'b1;
                reg_write_en = 1'b1;
            end
            OP_JAL: begin
                a_sel_pc     = 1'b1;
                link         = 1'b1;
                cond         = BR_ALWAYS;
                reg_write_en = 1'b1;
            end
            OP_JALR: begin
                link         = 1'b1;
                jalr         = 1'b1;
                cond         = BR_ALWAYS;
                reg_write_en = 1'b1;
            end
            OP_BRANCH: begin
                a_sel_pc = 1'b1;
                case (funct3)
                    3'b000:  cond = BR_EQ;
                    3'b001:  cond = BR_NE;
                    3'b100:  cond = BR_LT;
                    3'b101:  cond = BR_GE;
                    3'b110:  cond = BR_LTU;
                    3'b111:  cond = BR_GEU;
                    default: cond = BR_NONE;
                endcase
            end
            default: ;
        endcase
    end

    assign alu_op  = op;
    assign br_cond = cond;

endmodule

// File: rtl/rv_exec_unit.sv
// Execute/next-PC core of the single-cycle RV32I datapath: operand and
// result muxing around decoder, ALU and comparator, plus the PC register.
module rv_exec_unit
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_value,
    input  logic [31:0] rs2_value,
    input  logic [31:0] immediate,
    output logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic [31:0] rd_value,
    output logic        reg_write_en,
    output logic        branch
);

    logic [3:0]  alu_op;
    logic [2:0]  br_cond;
    logic        a_sel_pc;
    logic        b_sel_imm;
    logic        link;
    logic        jalr;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic [31:0] target;

    // Register indices are consumed by the register file, not here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    rv_ctrl u_ctrl (
        .opcode       (instr[6:0]),
        .funct3       (instr[14:12]),
        .funct7_5     (instr[30]),
        .alu_op       (alu_op),
        .br_cond      (br_cond),
        .a_sel_pc     (a_sel_pc),
        .b_sel_imm    (b_sel_imm),
        .link         (link),
        .jalr         (jalr),
        .reg_write_en (reg_write_en)
    );

    assign op_a = a_sel_pc  ? pc        : rs1_value;
    assign op_b = b_sel_imm ? immediate : rs2_value;

    rv_alu u_alu (
        .alu_op (alu_op),
        .a      (op_a),
        .b      (op_b),
        .result (alu_result)
    );

    rv_branch u_branch (
        .br_cond   (br_cond),
        .rs1_value (rs1_value),
        .rs2_value (rs2_value),
        .taken     (branch)
    );

    // The ALU computes every jump/branch target; JALR additionally drops bit 0.
    assign pc_plus4 = pc + 32'd4;
    assign target   = jalr ? {alu_result[31:1], 1'b0} : alu_result;
    assign pc_next  = branch ? target : pc_plus4;
    assign rd_value = link ? pc_plus4 : alu_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: tb/tb_rv_exec_unit.sv
// Self-checking bench for rv_exec_unit: instruction-level reference model
// checked every cycle, plus directed vectors with literal expectations.
module tb_rv_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] instr = 32'h0000_0013;
    logic [31:0] rs1_value = '0;
    logic [31:0] rs2_value = '0;
    logic [31:0] immediate = '0;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] rd_value;
    logic        reg_write_en;
    logic        branch;

    int checks = 0;
    int errors = 0;
    logic chk_on = 1'b0;
    logic [31:0] model_pc = '0;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] JR_X1   = 32'h0000_8067;
    localparam logic [31:0] IMM_M8  = 32'hFFFF_FFF8;

    typedef struct packed {
        logic [31:0] rd;
        logic [31:0] pcn;
        logic        we;
        logic        br;
    } exp_t;

    rv_exec_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .rs1_value    (rs1_value),
        .rs2_value    (rs2_value),
        .immediate    (immediate),
        .pc           (pc),
        .pc_next      (pc_next),
        .rd_value     (rd_value),
        .reg_write_en (reg_write_en),
        .branch       (branch)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] arith(input logic [2:0] f3, input logic alt, input logic is_r,
                                          input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return (is_r && alt) ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] im, input logic [31:0] p);
        exp_t e;
        logic [31:0] tgt;
        tgt  = p + im;
        e.rd = a + im;
        e.we = 1'b0;
        e.br = 1'b0;
        case (i[6:0])
            7'b0110011: begin e.rd = arith(i[14:12], i[30], 1'b1, a, b);  e.we = 1'b1; end
            7'b0010011: begin e.rd = arith(i[14:12], i[30], 1'b0, a, im); e.we = 1'b1; end
            7'b0110111: begin e.rd = im;     e.we = 1'b1; end
            7'b0010111: begin e.rd = p + im; e.we = 1'b1; end
            7'b1101111: begin e.rd = p + 4;  e.we = 1'b1; e.br = 1'b1; end
            7'b1100111: begin
                e.rd = p + 4; e.we = 1'b1; e.br = 1'b1;
                tgt  = (a + im) & ~32'd1;
            end
            7'b1100011: begin
                e.rd = p + im;
                case (i[14:12])
                    3'd0: e.br = (a == b);
                    3'd1: e.br = (a != b);
                    3'd4: e.br = ($signed(a) <  $signed(b));
                    3'd5: e.br = ($signed(a) >= $signed(b));
                    3'd6: e.br = (a <  b);
                    3'd7: e.br = (a >= b);
                    default: e.br = 1'b0;
                endcase
            end
            default: ;
        endcase
        e.pcn = e.br ? tgt : p + 4;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_pc <= '0;
        else        model_pc <= model(instr, rs1_value, rs2_value, immediate, model_pc).pcn;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            exp_t e;
            e = model(instr, rs1_value, rs2_value, immediate, model_pc);
            check("m_pc",      pc,                  model_pc);
            check("m_pc_next", pc_next,             e.pcn);
            check("m_rd",      rd_value,            e.rd);
            check("m_we",      {31'd0, reg_write_en}, {31'd0, e.we});
            check("m_branch",  {31'd0, branch},     {31'd0, e.br});
        end
    end

    task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im);
        @(posedge clk);
        #1;
        instr = i; rs1_value = a; rs2_value = b; immediate = im;
        #1;
    endtask

    task automatic goto(input logic [31:0] addr);
        drive(JR_X1, addr, '0, '0);
    endtask

    typedef struct packed {
        logic [31:0] i;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] im;
    } vec_t;

    vec_t table_v[12];

    initial begin
        table_v[0]  = '{32'h0080_00EF, 32'd0,        32'd0,      32'd8};
        table_v[1]  = '{32'h0000_1097, 32'd0,        32'd0,      32'h1000};
        table_v[2]  = '{32'hFE20_9CE3, 32'd1,        32'd2,      IMM_M8};
        table_v[3]  = '{32'hFE20_DCE3, 32'hFFFF_FFFF, 32'd1,     IMM_M8};
        table_v[4]  = '{32'hFE20_FCE3, 32'hFFFF_FFFF, 32'd1,     IMM_M8};
        table_v[5]  = '{32'hFE20_ACE3, 32'd5,        32'd5,      IMM_M8};
        table_v[6]  = '{32'h0020_F1B3, 32'h0000_F0F0, 32'h0000_FF00, 32'd0};
        table_v[7]  = '{32'h0020_E1B3, 32'h0000_F0F0, 32'h0000_FF00, 32'd0};
        table_v[8]  = '{32'h0020_C1B3, 32'h0000_F0F0, 32'h0000_FF00, 32'd0};
        table_v[9]  = '{32'h0020_91B3, 32'd1,        32'd35,     32'd0};
        table_v[10] = '{32'h0020_81B3, 32'hFFFF_FFFF, 32'd1,     32'd0};
        table_v[11] = '{32'h0020_A093, 32'hFFFF_FFFF, 32'd0,     32'd1};

        #1 rst_n = 1'b0;
        #1 chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("reset_pc", pc, 32'd0);
        check("reset_pc_next", pc_next, 32'd4);
        #1 rst_n = 1'b1;

        drive(NOP, '0, '0, '0);
        check("first_edge_pc", pc, 32'd4);
        drive(32'h4020_8033, 32'd5, 32'd7, '0);
        check("sub_rd", rd_value, 32'hFFFF_FFFE);
        check("sub_we", {31'd0, reg_write_en}, 32'd1);
        check("sub_branch", {31'd0, branch}, 32'd0);
        check("sub_pc_next", pc_next, 32'h0000_000C);

        drive(32'h4020_D1B3, 32'h8000_0000, 32'd4, '0);
        check("sra_rd", rd_value, 32'hF800_0000);
        drive(32'h0020_D1B3, 32'h8000_0000, 32'd4, '0);
        check("srl_rd", rd_value, 32'h0800_0000);
        drive(32'h0020_A1B3, 32'hFFFF_FFFF, 32'd1, '0);
        check("slt_rd", rd_value, 32'd1);
        drive(32'h0020_B1B3, 32'hFFFF_FFFF, 32'd1, '0);
        check("sltu_rd", rd_value, 32'd0);
        drive(32'h4000_8093, 32'd5, '0, 32'h400);
        check("addi_bit30_rd", rd_value, 32'h405);
        drive(32'h4040_D093, 32'h8000_0000, '0, 32'h404);
        check("srai_rd", rd_value, 32'hF800_0000);

        goto(32'h10);
        drive(32'hFE20_8CE3, 32'd3, 32'd3, IMM_M8);
        check("beq_t_branch", {31'd0, branch}, 32'd1);
        check("beq_t_pc_next", pc_next, 32'h08);
        check("beq_t_we", {31'd0, reg_write_en}, 32'd0);
        goto(32'h10);
        drive(32'hFE20_8CE3, 32'd3, 32'd4, IMM_M8);
        check("beq_nt_branch", {31'd0, branch}, 32'd0);
        check("beq_nt_pc_next", pc_next, 32'h14);

        goto(32'h10);
        drive(32'hFE20_CCE3, 32'hFFFF_FFFF, 32'd1, IMM_M8);
        check("blt_branch", {31'd0, branch}, 32'd1);
        drive(32'hFE20_ECE3, 32'hFFFF_FFFF, 32'd1, IMM_M8);
        check("bltu_branch", {31'd0, branch}, 32'd0);

        goto(32'h20);
        drive(32'h0040_80E7, 32'h101, '0, 32'd4);
        check("jalr_pc_next", pc_next, 32'h104);
        check("jalr_rd", rd_value, 32'h24);
        drive(32'h1234_50B7, '0, '0, 32'h1234_5000);
        check("lui_rd", rd_value, 32'h1234_5000);
        check("lui_we", {31'd0, reg_write_en}, 32'd1);
        drive(32'h0000_007F, 32'd9, 32'd9, 32'd0);
        check("unk_we", {31'd0, reg_write_en}, 32'd0);
        check("unk_branch", {31'd0, branch}, 32'd0);
        check("unk_pc_next", pc_next, 32'h10C);

        goto(32'hFFFF_FFFC);
        drive(NOP, '0, '0, '0);
        check("wrap_pc_next", pc_next, 32'd0);

        for (int k = 0; k < 12; k++) begin
            drive(table_v[k].i, table_v[k].a, table_v[k].b, table_v[k].im);
        end

        goto(32'h40);
        drive(NOP, '0, '0, '0);
        check("pre_reset_pc", pc, 32'h40);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_pc", pc, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        drive(NOP, '0, '0, '0);
        check("post_reset_pc", pc, 32'd4);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
